spi_byte_master: RTL and testbench
==================================

Name: spi_byte_master

Overview:
- Byte-wide SPI mode-0 master between the CPU port decode and the SD card power/sequencing block.
- Drives that block's in_sck and in_mosi, samples its in_miso, and drives its active-low enable_n select.
- The CPU writes a byte to start an exchange. It reads the last received byte, and that read also starts a pipelined 0xFF exchange.
- Two chip selects are provided: SD0 and SD1/expansion.

Parameters:
DIV_BITS  8  width of the SCK half-period divider register
DIV_RESET  8'd3  divider value loaded on reset; half-period = div+1 clk_peripheral cycles

Ports:
clk_peripheral  in  1  system peripheral clock
reset  in  1  asynchronous active-high reset
data_wr  in  1  one-cycle strobe: start exchange transmitting data_in
data_rd  in  1  one-cycle strobe: CPU read of data_out; starts exchange transmitting 8'hFF
data_in  in  8  byte to transmit
data_out  out  8  last fully received byte
cs_wr  in  1  one-cycle strobe: load cs_in into chip-select register
cs_in  in  2  new chip-select value, active low
div_wr  in  1  one-cycle strobe: load div_in into divider register
div_in  in  DIV_BITS  new divider value
busy  out  1  high while an exchange is in progress
spi_sck  out  1  to in_sck of SD block
spi_mosi  out  1  to in_mosi of SD block
spi_miso  in  1  from in_miso of SD block
spi_cs_n  out  2  bit0 to SD block enable_n; bit1 to second device

Behaviour:
- Reset values:
  - spi_sck=0, spi_mosi=1, spi_cs_n=2'b11, busy=0, data_out=8'hFF, divider=DIV_RESET.
  - State is IDLE. Shift and edge counters are 0.
- Let H = divider+1. The divider value is captured into a working copy when an exchange starts. A div_wr during an exchange affects only the next exchange.
- FSM states:
  - IDLE: sck=0.
    - A strobe sampled at edge N moves the FSM to LOW, with busy=1 and spi_mosi=tx[7] from edge N.
    - tx is data_in for data_wr, or 8'hFF for data_rd.
  - LOW: sck=0 for H cycles, then go to HIGH.
    - On entering HIGH, spi_sck=1 and spi_miso is shifted into rx LSB.
  - HIGH: sck=1 for H cycles, then sck=0 and a bit counter increments.
    - If the count is <8: shift tx left, drive spi_mosi=next bit (MSB first), go to LOW.
    - If the count is 8: go to DONE.
  - DONE (1 cycle): data_out<=rx, busy=0, spi_mosi=1, then go to IDLE.
- Timing:
  - Exchange length from busy rise to busy fall is 16*H+1 cycles.
  - MOSI changes only on SCK falling edges, or at exchange start.
  - MISO is sampled on the clk_peripheral edge that raises SCK.
- data_out holds its value throughout an exchange. A data_rd returns the old data_out, so the CPU sees the previous byte: the pipelined read model.
- Strobes while busy=1 (data_wr or data_rd) are ignored entirely: no queueing, tx is not overwritten.
- data_wr and data_rd asserted together in IDLE: data_wr wins and data_in is sent.
- cs_wr takes effect the next cycle in any state, including mid-exchange; the exchange continues.
- cs_wr and data_wr in the same cycle: both are accepted.
- div_in=0 gives H=1: SCK toggles every clk cycle. Maximum divider value is 2^DIV_BITS-1, with no wrap in H computation; H is DIV_BITS+1 bits wide.
- Reset asserted mid-exchange: all outputs return to their reset values immediately (asynchronously), the partial rx is discarded, and the SD block sees sck=0 and enable_n=1.

Test Plan:
1. Reset check
   - Stimulus: reset pulse, no strobes.
   - Required response: spi_cs_n=11, spi_sck=0, spi_mosi=1, busy=0, data_out=FF.
2. Write exchange, default divider
   - Stimulus: cs_wr with cs_in=10, then data_wr with data_in=A5; MISO model returns 3C MSB first.
   - Required response: MOSI sampled on 8 SCK rises = 1,0,1,0,0,1,0,1; busy high for 65 cycles; then data_out=3C.
3. Pipelined read, fastest clock
   - Stimulus: div_wr with div_in=0, then data_rd; MISO returns 81.
   - Required response: data_out reads 3C at the strobe; MOSI=1 for all bits; SCK period=2 clks; busy lasts 17 cycles; then data_out=81.
4. Collisions
   - Stimulus: data_wr 55 while busy mid-exchange.
   - Required response: transmitted byte unchanged, no second exchange.
   - Stimulus: data_wr 12 and data_rd in the same IDLE cycle.
   - Required response: 12 is sent.
5. Divider and chip-select change mid-exchange
   - Stimulus: div_wr with div_in=7 during an H=1 exchange.
   - Required response: the current exchange keeps H=1; the next exchange has H=8 (129 cycles).
   - Stimulus: cs_wr with cs_in=11 mid-exchange.
   - Required response: spi_cs_n=11 the next cycle; SCK continues.
6. Reset mid-exchange
   - Stimulus: assert reset at bit 4 of an exchange.
   - Required response: outputs return to reset values within the same cycle; data_out=FF; after release, a new data_wr starts cleanly.

Source files
------------

// File: rtl/spi_byte_master.sv
// spi_byte_master: byte-wide SPI mode-0 master for the SD power/sequencing block.
// CPU write or pipelined read starts one 8-bit exchange; two active-low selects.
module spi_byte_master #(
  parameter int unsigned          DIV_BITS  = 8,
  parameter logic [DIV_BITS-1:0]  DIV_RESET = DIV_BITS'(3)
) (
  input  logic                clk_peripheral,
  input  logic                reset,
  input  logic                data_wr,
  input  logic                data_rd,
  input  logic [7:0]          data_in,
  output logic [7:0]          data_out,
  input  logic                cs_wr,
  input  logic [1:0]          cs_in,
  input  logic                div_wr,
  input  logic [DIV_BITS-1:0] div_in,
  output logic                busy,
  output logic                spi_sck,
  output logic                spi_mosi,
  input  logic                spi_miso,
  output logic [1:0]          spi_cs_n
);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_t;

  state_t state, state_n;

  logic [DIV_BITS-1:0] div;
  logic [DIV_BITS-1:0] div_work;
  logic [DIV_BITS-1:0] cnt;
  logic [3:0]          bit_cnt;
  logic [7:0]          tx;
  logic [7:0]          rx;
  logic [7:0]          tx_sel;
  logic                start;
  logic                phase_end;
  logic                last_bit;

  // Half-period ends after div_work+1 cycles; compare avoids any H overflow.
  assign phase_end = (cnt == div_work);
  assign last_bit  = (bit_cnt == 4'd7);
  assign start     = (state == IDLE) && (data_wr || data_rd);
  assign tx_sel    = data_wr ? data_in : 8'hFF;

  // State register
  always_ff @(posedge clk_peripheral or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state decode
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start) state_n = LOW;
      LOW:  if (phase_end) state_n = HIGH;
      HIGH: if (phase_end) state_n = last_bit ? DONE : LOW;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Chip-select and divider registers, writable in any state
  always_ff @(posedge clk_peripheral or posedge reset) begin
    if (reset) begin
      spi_cs_n <= 2'b11;
      div      <= DIV_RESET;
    end else begin
      if (cs_wr)  spi_cs_n <= cs_in;
      if (div_wr) div      <= div_in;
    end
  end

  // Exchange datapath: counters, shift registers and SPI pins
  always_ff @(posedge clk_peripheral or posedge reset) begin
    if (reset) begin
      spi_sck  <= 1'b0;
      spi_mosi <= 1'b1;
      busy     <= 1'b0;
      data_out <= 8'hFF;
      div_work <= '0;
      cnt      <= '0;
      bit_cnt  <= '0;
      tx       <= 8'hFF;
      rx       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          spi_sck <= 1'b0;
          if (start) begin
            tx       <= tx_sel;
            spi_mosi <= tx_sel[7];
            busy     <= 1'b1;
            div_work <= div;
            cnt      <= '0;
            bit_cnt  <= '0;
          end
        end
        LOW: begin
          if (phase_end) begin
            cnt     <= '0;
            spi_sck <= 1'b1;
            rx      <= {rx[6:0], spi_miso};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HIGH: begin
          if (phase_end) begin
            cnt     <= '0;
            spi_sck <= 1'b0;
            bit_cnt <= bit_cnt + 4'd1;
            if (last_bit) begin
              spi_mosi <= 1'b1;
            end else begin
              tx       <= {tx[6:0], 1'b0};
              spi_mosi <= tx[6];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          data_out <= rx;
          busy     <= 1'b0;
          spi_mosi <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_byte_master.sv
// tb_spi_byte_master: directed vectors for spi_byte_master.
// Slave model drives MISO MSB first; monitor captures MOSI on SCK rises.
module tb_spi_byte_master;

  logic       clk_peripheral = 1'b0;
  logic       reset = 1'b1;
  logic       data_wr = 1'b0;
  logic       data_rd = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       cs_wr = 1'b0;
  logic [1:0] cs_in = 2'b11;
  logic       div_wr = 1'b0;
  logic [7:0] div_in = 8'h00;
  logic       busy;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_miso;
  logic [1:0] spi_cs_n;

  logic [7:0] slave_byte = 8'h00;

  int n_chk = 0;
  int n_pass = 0;

  int nrise = 0;
  int nfall = 0;
  int busy_cyc = 0;
  int hi_cyc = 0;
  int n_ex = 0;
  int mosi_bad = 0;
  int ex0;
  logic [7:0] mosi_cap = 8'h00;
  logic busy_q = 1'b0;
  logic sck_q = 1'b0;
  logic mosi_q = 1'b1;

  spi_byte_master dut (
    .clk_peripheral(clk_peripheral),
    .reset(reset),
    .data_wr(data_wr),
    .data_rd(data_rd),
    .data_in(data_in),
    .data_out(data_out),
    .cs_wr(cs_wr),
    .cs_in(cs_in),
    .div_wr(div_wr),
    .div_in(div_in),
    .busy(busy),
    .spi_sck(spi_sck),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .spi_cs_n(spi_cs_n)
  );

  always #5 clk_peripheral = ~clk_peripheral;

  assign spi_miso = slave_byte[3'(7 - nfall)];

  always @(negedge clk_peripheral) begin
    if (busy && !busy_q) begin
      nrise = 0;
      nfall = 0;
      busy_cyc = 0;
      hi_cyc = 0;
      mosi_cap = 8'h00;
      n_ex++;
    end
    if (busy) busy_cyc++;
    if (spi_sck) hi_cyc++;
    if (spi_sck && !sck_q) begin
      mosi_cap = {mosi_cap[6:0], spi_mosi};
      nrise++;
    end
    if (!spi_sck && sck_q) nfall++;
    if (!reset && (spi_mosi != mosi_q) &&
        !(!spi_sck && sck_q) && !(busy && !busy_q))
      mosi_bad++;
    busy_q = busy;
    sck_q = spi_sck;
    mosi_q = spi_mosi;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk_peripheral);
      #1;
    end
  endtask

  task automatic wait_idle(input string tag);
    int budget = 2000;
    while (busy && budget > 0) begin
      tick();
      budget--;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic xfer_wr(input logic [7:0] b);
    data_in = b;
    data_wr = 1'b1;
    tick();
    data_wr = 1'b0;
  endtask

  initial begin
    tick(3);
    check("rst_hold_sck", 32'(spi_sck), 32'd0);
    reset = 1'b0;
    tick(2);
    check("rst_cs", 32'(spi_cs_n), 32'h3);
    check("rst_sck", 32'(spi_sck), 32'd0);
    check("rst_mosi", 32'(spi_mosi), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dout", 32'(data_out), 32'hFF);

    // Write A5, slave returns 3C, default divider H=4
    cs_in = 2'b10;
    cs_wr = 1'b1;
    tick();
    cs_wr = 1'b0;
    check("cs_10", 32'(spi_cs_n), 32'h2);
    slave_byte = 8'h3C;
    xfer_wr(8'hA5);
    check("wr_busy", 32'(busy), 32'd1);
    check("wr_mosi0", 32'(spi_mosi), 32'd1);
    check("wr_dout_hold", 32'(data_out), 32'hFF);
    wait_idle("wr_tmo");
    check("wr_mosi", 32'(mosi_cap), 32'hA5);
    check("wr_rises", 32'(nrise), 32'd8);
    check("wr_busy_cyc", 32'(busy_cyc), 32'd65);
    check("wr_hi_cyc", 32'(hi_cyc), 32'd32);
    check("wr_dout", 32'(data_out), 32'h3C);

    // Pipelined read at H=1, slave returns 81
    div_in = 8'd0;
    div_wr = 1'b1;
    tick();
    div_wr = 1'b0;
    slave_byte = 8'h81;
    check("rd_old", 32'(data_out), 32'h3C);
    data_rd = 1'b1;
    tick();
    data_rd = 1'b0;
    check("rd_busy", 32'(busy), 32'd1);
    check("rd_hold", 32'(data_out), 32'h3C);
    wait_idle("rd_tmo");
    check("rd_mosi", 32'(mosi_cap), 32'hFF);
    check("rd_busy_cyc", 32'(busy_cyc), 32'd17);
    check("rd_hi_cyc", 32'(hi_cyc), 32'd8);
    check("rd_rises", 32'(nrise), 32'd8);
    check("rd_dout", 32'(data_out), 32'h81);

    // Strobe while busy is dropped
    slave_byte = 8'h00;
    ex0 = n_ex;
    xfer_wr(8'h96);
    tick(4);
    xfer_wr(8'h55);
    data_rd = 1'b1;
    tick();
    data_rd = 1'b0;
    wait_idle("col_tmo");
    tick(3);
    check("col_mosi", 32'(mosi_cap), 32'h96);
    check("col_n_ex", 32'(n_ex - ex0), 32'd1);
    check("col_idle", 32'(busy), 32'd0);
    check("col_dout", 32'(data_out), 32'h00);

    // data_wr and data_rd together: write wins
    slave_byte = 8'h6B;
    data_in = 8'h12;
    data_wr = 1'b1;
    data_rd = 1'b1;
    tick();
    data_wr = 1'b0;
    data_rd = 1'b0;
    wait_idle("both_tmo");
    check("both_mosi", 32'(mosi_cap), 32'h12);
    check("both_dout", 32'(data_out), 32'h6B);

    // Divider and chip select changed mid-exchange
    slave_byte = 8'hC3;
    xfer_wr(8'hF0);
    div_in = 8'd7;
    div_wr = 1'b1;
    tick();
    div_wr = 1'b0;
    tick();
    cs_in = 2'b11;
    cs_wr = 1'b1;
    tick();
    cs_wr = 1'b0;
    check("mid_cs", 32'(spi_cs_n), 32'h3);
    check("mid_busy", 32'(busy), 32'd1);
    wait_idle("mid_tmo");
    check("mid_busy_cyc", 32'(busy_cyc), 32'd17);
    check("mid_rises", 32'(nrise), 32'd8);
    check("mid_mosi", 32'(mosi_cap), 32'hF0);
    check("mid_dout", 32'(data_out), 32'hC3);
    slave_byte = 8'h5A;
    xfer_wr(8'h3A);
    wait_idle("h8_tmo");
    check("h8_busy_cyc", 32'(busy_cyc), 32'd129);
    check("h8_hi_cyc", 32'(hi_cyc), 32'd64);
    check("h8_mosi", 32'(mosi_cap), 32'h3A);
    check("h8_dout", 32'(data_out), 32'h5A);

    // Reset mid-exchange, with cs_wr accepted alongside data_wr
    slave_byte = 8'hE7;
    cs_in = 2'b00;
    cs_wr = 1'b1;
    xfer_wr(8'hC3);
    cs_wr = 1'b0;
    check("cswr_cs", 32'(spi_cs_n), 32'h0);
    check("cswr_busy", 32'(busy), 32'd1);
    begin
      int budget = 1000;
      while (nrise < 4 && budget > 0) begin
        tick();
        budget--;
      end
    end
    check("bit4_reached", 32'(nrise), 32'd4);
    check("bit4_sck", 32'(spi_sck), 32'd1);
    check("bit4_mosi", 32'(spi_mosi), 32'd0);
    reset = 1'b1;
    #1;
    check("arst_sck", 32'(spi_sck), 32'd0);
    check("arst_mosi", 32'(spi_mosi), 32'd1);
    check("arst_cs", 32'(spi_cs_n), 32'h3);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_dout", 32'(data_out), 32'hFF);
    tick(2);
    reset = 1'b0;
    tick();
    slave_byte = 8'h99;
    xfer_wr(8'h5A);
    check("post_busy", 32'(busy), 32'd1);
    wait_idle("post_tmo");
    check("post_busy_cyc", 32'(busy_cyc), 32'd65);
    check("post_mosi", 32'(mosi_cap), 32'h5A);
    check("post_dout", 32'(data_out), 32'h99);
    check("mosi_on_fall", 32'(mosi_bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
